// File: rtl/demux_1to2_stream_pkg.sv
// Shared definitions for the packet-aware 1-to-2 stream demultiplexer.
//   state_e    : packet-tracking FSM states (idle between packets, locked inside one)
//   Out0/Out1  : destination select encodings (s.sel / cur_sel values)
//   route_sel  : destination for the beat currently offered on the input
package demux_1to2_stream_pkg;

  typedef enum logic {
    StIdle   = 1'b0,
    StLocked = 1'b1
  } state_e;

  localparam logic Out0 = 1'b0;
  localparam logic Out1 = 1'b1;

  // Between packets the beat carries its own destination; inside a packet the destination
  // latched on the first beat wins and the per-beat select is ignored.
  function automatic logic route_sel(state_e st, logic in_sel, logic held_sel);
    return (st == StIdle) ? in_sel : held_sel;
  endfunction

endpackage

// File: rtl/demux_1to2_stream_if.sv
// Valid/ready packet stream bundle.
//   valid : beat valid (master -> slave)
//   ready : beat accepted when valid && ready (slave -> master)
//   data  : payload, DATA_W bits (master -> slave)
//   last  : final beat of packet (master -> slave)
//   sel   : destination select, meaningful on the demux input only (master -> slave);
//           on the demux outputs it carries the constant index of that output
interface demux_1to2_stream_if #(
  parameter int unsigned DATA_W = 8
) ();

  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic              last;
  logic              sel;

  modport master (
    output valid,
    output data,
    output last,
    output sel,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    input  last,
    input  sel,
    output ready
  );

endinterface

// File: rtl/demux_1to2_stream_out_slot.sv
// One-entry registered valid/ready output stage with a completed-packet counter.
//   clk, rst_n  : clock, asynchronous active-low reset
//   load        : write a beat into the slot this cycle (only asserted when can_accept)
//   load_data   : payload to write
//   load_last   : last flag to write
//   can_accept  : slot empty or draining this cycle
//   m           : output stream (master side)
//   pkt_cnt     : packets fully delivered (handshake with last), wraps around
module demux_1to2_stream_out_slot
  import demux_1to2_stream_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 8,
  parameter logic        DEST   = Out0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [DATA_W-1:0]  load_data,
  input  logic               load_last,
  output logic               can_accept,
  demux_1to2_stream_if.master m,
  output logic [CNT_W-1:0]   pkt_cnt
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              last_q, last_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              drain;

  assign drain      = valid_q && m.ready;
  assign can_accept = !valid_q || m.ready;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    // A refill in the same cycle as a drain keeps the slot full with the new beat.
    if (load) begin
      valid_d = 1'b1;
      data_d  = load_data;
      last_d  = load_last;
    end else if (drain) begin
      valid_d = 1'b0;
    end
    if (drain && last_q) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  assign m.valid = valid_q;
  assign m.data  = data_q;
  assign m.last  = last_q;
  assign m.sel   = DEST;
  assign pkt_cnt = cnt_q;

endmodule

// File: rtl/demux_1to2_stream.sv
// Packet-aware 1-to-2 stream demultiplexer. Each whole packet goes to m0 or m1, chosen by
// s.sel on the packet's first beat; later beats follow the latched destination.
//   clk, rst_n : clock, asynchronous active-low reset
//   s          : input stream (slave side); s.sel sampled on first beat only
//   m0, m1     : output streams, each behind a one-entry registered slot
//   busy       : a packet is in progress (first beat accepted, last not yet)
//   cur_sel    : latched destination of the current/last packet
//   pkt_cnt0/1 : packets fully delivered on m0/m1, wrap-around
module demux_1to2_stream
  import demux_1to2_stream_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  demux_1to2_stream_if.slave  s,
  demux_1to2_stream_if.master m0,
  demux_1to2_stream_if.master m1,
  output logic               busy,
  output logic               cur_sel,
  output logic [CNT_W-1:0]   pkt_cnt0,
  output logic [CNT_W-1:0]   pkt_cnt1
);

  state_e state_q, state_d;
  logic   cur_sel_q, cur_sel_d;
  logic   route;
  logic   accept;
  logic   can0, can1;
  logic   load0, load1;

  // s.ready looks only at the targeted slot, so a stalled non-target output never blocks.
  assign route   = route_sel(state_q, s.sel, cur_sel_q);
  assign s.ready = (route == Out1) ? can1 : can0;
  assign accept  = s.valid && s.ready;
  assign load0   = accept && (route == Out0);
  assign load1   = accept && (route == Out1);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cur_sel_q <= Out0;
    end else begin
      state_q   <= state_d;
      cur_sel_q <= cur_sel_d;
    end
  end

  // Next state.
  always_comb begin
    state_d   = state_q;
    cur_sel_d = cur_sel_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          cur_sel_d = s.sel;
          // A single-beat packet completes immediately and leaves the FSM idle.
          if (!s.last) begin
            state_d = StLocked;
          end
        end
      end
      StLocked: begin
        if (accept && s.last) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs.
  always_comb begin
    busy    = (state_q == StLocked);
    cur_sel = cur_sel_q;
  end

  demux_1to2_stream_out_slot #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W),
    .DEST   (Out0)
  ) u_slot0 (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load0),
    .load_data  (s.data),
    .load_last  (s.last),
    .can_accept (can0),
    .m          (m0),
    .pkt_cnt    (pkt_cnt0)
  );

  demux_1to2_stream_out_slot #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W),
    .DEST   (Out1)
  ) u_slot1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load1),
    .load_data  (s.data),
    .load_last  (s.last),
    .can_accept (can1),
    .m          (m1),
    .pkt_cnt    (pkt_cnt1)
  );

endmodule
